lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/sat_counter.sv | 33 +++
 rtl/lfsr_checker.sv | 131 +++++++++++++
 tb/tb_lfsr_checker.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit XNOR LFSR: width, lockup value, checker FSM states and the
// next-value function used by both the upstream counter and the checker.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned TAP_HI = 7;
  localparam int unsigned TAP_LO = 3;

  // XNOR feedback never leaves the all-ones state, so it can never be a valid seed.
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = '1;

  typedef enum logic [1:0] {
    StHunt,
    StVerify,
    StLocked
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], ~(x[TAP_HI] ^ x[TAP_LO])};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// Lock/track checker for an 8-bit XNOR LFSR stream with flywheel and saturating error count.
// Define LFSR_CHECKER_LOSS_CNT_EN to add the loss_cnt output (count of lock losses).
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [LFSR_W-1:0] din,
  input  logic              clr_err,
  output logic              locked,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt
`ifdef LFSR_CHECKER_LOSS_CNT_EN
  ,
  output logic [7:0]        loss_cnt
`endif
);

  localparam logic [3:0] LockTgt = 4'(LOCK_CNT);
  localparam logic [3:0] LossTgt = 4'(LOSS_CNT);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [3:0]        match_q, match_d;
  logic [3:0]        miss_q, miss_d;
  logic              locked_q;
  logic              err_q, err_d;
  logic              hit;

  assign hit = (din == exp_q);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    if (en) begin
      unique case (state_q)
        StHunt: begin
          if (din != LFSR_LOCKUP) begin
            exp_d   = lfsr_next(din);
            match_d = '0;
            state_d = StVerify;
          end
        end
        StVerify: begin
          if (hit) begin
            match_d = match_q + 4'd1;
            exp_d   = lfsr_next(din);
            if (match_d == LockTgt) begin
              state_d = StLocked;
              miss_d  = '0;
            end
          end else begin
            // Drop back without reseeding; the next valid sample seeds a fresh attempt.
            state_d = StHunt;
          end
        end
        StLocked: begin
          if (hit) begin
            miss_d = '0;
            exp_d  = lfsr_next(din);
          end else begin
            // Flywheel: advance our own prediction rather than trusting the bad sample.
            err_d  = 1'b1;
            exp_d  = lfsr_next(exp_q);
            miss_d = miss_q + 4'd1;
            if (miss_d == LossTgt) begin
              state_d = StHunt;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StHunt;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= (state_d == StLocked);
      err_q    <= err_d;
    end
  end

  assign locked = locked_q;
  assign err    = err_q;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_d),
    .clr  (clr_err),
    .q    (err_cnt)
  );

`ifdef LFSR_CHECKER_LOSS_CNT_EN
  logic loss_evt;

  assign loss_evt = en && (state_q == StLocked) && (state_d == StHunt);

  sat_counter #(
    .WIDTH(8)
  ) u_loss_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (loss_evt),
    .clr  (clr_err),
    .q    (loss_cnt)
  );
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: default instance plus a CNT_W=4 instance on shared stimulus.
module tb_lfsr_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        clr_err = 1'b0;
  logic        locked_a, err_a, locked_b, err_b;
  logic [15:0] err_cnt_a;
  logic [3:0]  err_cnt_b;
  logic [7:0]  la, lb;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_mode;  // 0 hunt, 1 verify, 2 locked
  logic [7:0] m_exp;
  int         m_match, m_miss, m_cnt16, m_cnt4, m_loss;
  bit         m_locked, m_err;

  always #5 clk = ~clk;

  lfsr_checker u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .din     (din),
    .clr_err (clr_err),
    .locked  (locked_a),
    .err     (err_a),
    .err_cnt (err_cnt_a)
`ifdef LFSR_CHECKER_LOSS_CNT_EN
    ,
    .loss_cnt(la)
`endif
  );

  lfsr_checker #(
    .CNT_W(4)
  ) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .din     (din),
    .clr_err (clr_err),
    .locked  (locked_b),
    .err     (err_b),
    .err_cnt (err_cnt_b)
`ifdef LFSR_CHECKER_LOSS_CNT_EN
    ,
    .loss_cnt(lb)
`endif
  );

`ifndef LFSR_CHECKER_LOSS_CNT_EN
  assign la = 8'h00;
  assign lb = 8'h00;
`endif

  function automatic logic [7:0] m_next(input logic [7:0] x);
    int v;
    v = int'(x);
    return 8'(((v << 1) & 'hFE) | ((~((v >> 7) ^ (v >> 3))) & 1));
  endfunction

  function automatic logic [39:0] obs();
    return {locked_a, err_a, err_cnt_a, locked_b, err_b, err_cnt_b, la, lb};
  endfunction

  function automatic logic [39:0] want();
    logic [7:0] l;
`ifdef LFSR_CHECKER_LOSS_CNT_EN
    l = 8'(m_loss);
`else
    l = 8'h00;
`endif
    return {m_locked, m_err, 16'(m_cnt16), m_locked, m_err, 4'(m_cnt4), l, l};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_exp = 8'h00; m_match = 0; m_miss = 0;
    m_cnt16 = 0; m_cnt4 = 0; m_loss = 0; m_locked = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit e, input logic [7:0] d, input bit c);
    bit lost;
    lost  = 0;
    m_err = 0;
    if (e) begin
      if (m_mode == 0) begin
        if (d != 8'hFF) begin
          m_exp = m_next(d); m_match = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (d == m_exp) begin
          m_match++;
          m_exp = m_next(d);
          if (m_match == LOCK_N) begin
            m_mode = 2; m_miss = 0;
          end
        end else begin
          m_mode = 0;
        end
      end else begin
        if (d == m_exp) begin
          m_miss = 0; m_exp = m_next(d);
        end else begin
          m_err = 1; m_exp = m_next(m_exp); m_miss++;
          if (m_miss == LOSS_N) begin
            m_mode = 0; lost = 1;
          end
        end
      end
    end
    if (c) begin
      m_cnt16 = 0; m_cnt4 = 0; m_loss = 0;
    end else begin
      if (m_err && m_cnt16 < 65535) m_cnt16++;
      if (m_err && m_cnt4 < 15) m_cnt4++;
      if (lost && m_loss < 255) m_loss++;
    end
    m_locked = (m_mode == 2);
  endtask

  task automatic step(input bit e, input logic [7:0] d, input bit c);
    @(negedge clk);
    en = e; din = d; clr_err = c;
    @(posedge clk);
    model_edge(e, d, c);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs() !== want()) begin
      n_errors++; $display("FAIL reset_state: got %h want %h", obs(), want());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_acquire();
    logic [7:0] seq [5];
    seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    for (int i = 0; i < 5; i++) begin
      step(1, seq[i], 0);
      n_checks++;
      if (obs() !== want()) begin
        n_errors++; $display("FAIL acquire[%0d]: got %h want %h", i, obs(), want());
      end
    end
    n_checks++;
    if (locked_a !== 1'b1 || err_cnt_a !== 16'd0) begin
      n_errors++; $display("FAIL acquire_lock: got locked=%b cnt=%0d want 1/0", locked_a, err_cnt_a);
    end
  endtask

  task automatic test_single_error();
    step(1, 8'h55, 0);
    n_checks++;
    if (err_a !== 1'b1 || err_cnt_a !== 16'd1 || locked_a !== 1'b1) begin
      n_errors++;
      $display("FAIL single_err: got err=%b cnt=%0d lk=%b want 1/1/1", err_a, err_cnt_a, locked_a);
    end
    step(1, 8'h3C, 0);
    n_checks++;
    if (obs() !== want() || err_a !== 1'b0 || locked_a !== 1'b1) begin
      n_errors++; $display("FAIL flywheel_match: got %h want %h", obs(), want());
    end
  endtask

  task automatic test_loss_relock();
    logic [7:0] seq [5];
    seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    step(0, 8'h99, 1);  // clear while idle must not disturb lock
    n_checks++;
    if (obs() !== want() || locked_a !== 1'b1 || err_cnt_a !== 16'd0) begin
      n_errors++; $display("FAIL clr_idle: got %h want %h", obs(), want());
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 8'hAA, 0);
      n_checks++;
      if (obs() !== want() || err_a !== 1'b1) begin
        n_errors++; $display("FAIL loss_miss[%0d]: got %h want %h", i, obs(), want());
      end
    end
    n_checks++;
    if (locked_a !== 1'b0 || err_cnt_a !== 16'd3) begin
      n_errors++; $display("FAIL loss_drop: got lk=%b cnt=%0d want 0/3", locked_a, err_cnt_a);
    end
`ifdef LFSR_CHECKER_LOSS_CNT_EN
    n_checks++;
    if (la !== 8'd1) begin
      n_errors++; $display("FAIL loss_cnt: got %0d want 1", la);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      step(1, seq[i], 0);
      n_checks++;
      if (obs() !== want()) begin
        n_errors++; $display("FAIL relock[%0d]: got %h want %h", i, obs(), want());
      end
    end
    n_checks++;
    if (locked_a !== 1'b1) begin
      n_errors++; $display("FAIL relock_final: got %b want 1", locked_a);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      step(1, m_exp ^ 8'h5A, 0);
      n_checks++;
      if (obs() !== want()) begin
        n_errors++; $display("FAIL sat_miss[%0d]: got %h want %h", i, obs(), want());
      end
      step(1, m_exp, 0);
      n_checks++;
      if (obs() !== want()) begin
        n_errors++; $display("FAIL sat_hit[%0d]: got %h want %h", i, obs(), want());
      end
    end
    n_checks++;
    if (err_cnt_b !== 4'hF || err_cnt_a !== 16'd23 || locked_a !== 1'b1) begin
      n_errors++;
      $display("FAIL saturate: got b=%0d a=%0d lk=%b want 15/23/1", err_cnt_b, err_cnt_a, locked_a);
    end
    step(1, m_exp ^ 8'h5A, 1);
    n_checks++;
    if (err_a !== 1'b1 || err_cnt_a !== 16'd0 || err_cnt_b !== 4'd0) begin
      n_errors++;
      $display("FAIL clr_wins: got err=%b a=%0d b=%0d want 1/0/0", err_a, err_cnt_a, err_cnt_b);
    end
  endtask

  task automatic test_async_reset();
    step(1, m_exp ^ 8'h11, 0);  // leaves err_cnt nonzero and lock held
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (locked_a !== 1'b0 || locked_b !== 1'b0 || err_cnt_a !== 16'd0 || err_a !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got lk=%b cnt=%0d err=%b want 0/0/0", locked_a, err_cnt_a, err_a);
    end
    model_reset();
`ifdef LFSR_CHECKER_LOSS_CNT_EN
    n_checks++;
    if (la !== 8'd0) begin
      n_errors++; $display("FAIL async_loss: got %0d want 0", la);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (obs() !== want()) begin
      n_errors++; $display("FAIL post_reset: got %h want %h", obs(), want());
    end
  endtask

  task automatic test_ff_hunt_gaps();
    logic [7:0] seq [5];
    seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    for (int i = 0; i < 5; i++) begin
      step(1, 8'hFF, 0);
      n_checks++;
      if (obs() !== want() || locked_a !== 1'b0) begin
        n_errors++; $display("FAIL ff_hunt[%0d]: got %h want %h", i, obs(), want());
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 8'($urandom), 0);
      n_checks++;
      if (obs() !== want()) begin
        n_errors++; $display("FAIL gap_hold[%0d]: got %h want %h", i, obs(), want());
      end
      step(1, seq[i], 0);
      n_checks++;
      if (obs() !== want() || locked_a !== (i == 4)) begin
        n_errors++; $display("FAIL gap_seq[%0d]: got %h want %h", i, obs(), want());
      end
    end
  endtask

  task automatic test_random();
    bit         e, c;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom % 5) != 0;
      c = ($urandom % 40) == 0;
      if (($urandom % 4) != 0) d = m_exp;
      else if (($urandom % 8) == 0) d = 8'hFF;
      else d = 8'($urandom);
      step(e, d, c);
      n_checks++;
      if (obs() !== want()) begin
        n_errors++; $display("FAIL random[%0d]: got %h want %h", i, obs(), want());
      end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_single_error();
    test_loss_relock();
    test_saturation();
    test_async_reset();
    test_ff_hunt_gaps();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
